// File: rtl/ras_predictor_pkg.sv
// Shared constants for the RAS stage: branch type codes, bus width and value aliases.
// Build option RAS_RECURSION_CNT_EN adds per-entry repeat counters.
package ras_predictor_pkg;

    localparam int InstAddrBus = 32;
    localparam logic AbleValue = 1'b1;
    localparam logic EnableValue = 1'b1;
    localparam logic [InstAddrBus-1:0] ZeorDate = '0;

    typedef enum logic [2:0] {
        TypeFORMAL = 3'd0,
        TypeBRANCH = 3'd1,
        TypeJUMP   = 3'd2,
        TypeCALL   = 3'd3,
        TypeRET    = 3'd4
    } ras_type_e;

`ifdef RAS_RECURSION_CNT_EN
    localparam logic [3:0] CtrMax = 4'hF;
`endif

endpackage

// File: rtl/ras_stack_mem.sv
// Circular return-address array: one synchronous write port, one combinational read port.
// Under RAS_RECURSION_CNT_EN each entry also stores a 4-bit repeat counter.
module ras_stack_mem
    import ras_predictor_pkg::*;
#(
    parameter int RAS_DEPTH = 16,
    parameter int PTR_W     = 4,
    parameter int ADDR_W    = InstAddrBus
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_idx,
    input  logic [ADDR_W-1:0] wr_addr,
`ifdef RAS_RECURSION_CNT_EN
    input  logic [3:0]        wr_ctr,
    output logic [3:0]        rd_ctr,
`endif
    input  logic [PTR_W-1:0]  rd_idx,
    output logic [ADDR_W-1:0] rd_addr
);

    // Contents deliberately survive reset; occupancy alone says what is valid.
    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= wr_addr;
    end

    assign rd_addr = mem_q[rd_idx];

`ifdef RAS_RECURSION_CNT_EN
    logic [3:0] ctr_q [RAS_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) ctr_q[wr_idx] <= wr_ctr;
    end

    assign rd_ctr = ctr_q[rd_idx];
`endif

endmodule

// File: rtl/ras_predictor.sv
// Return Address Stack stage after the BTB: pushes on CALL, overrides target on RET,
// registers the final next-PC with a top/occupancy checkpoint. Option: RAS_RECURSION_CNT_EN.
module ras_predictor
    import ras_predictor_pkg::*;
#(
    parameter int RAS_DEPTH = 16,
    parameter int PTR_W     = 4,
    parameter int ADDR_W    = InstAddrBus
) (
    input  logic              Clk,
    input  logic              Rest,
    input  logic              InstNextAble,
    input  logic [ADDR_W-1:0] InstNextPc,
    input  logic [2:0]        InstNextType,
    input  logic [ADDR_W-1:0] InstCallPc,
    input  logic              RecoverAble,
    input  logic [PTR_W-1:0]  RecoverTop,
    input  logic [PTR_W:0]    RecoverCnt,
    output logic              RasNextAble,
    output logic [ADDR_W-1:0] RasNextPc,
    output logic [2:0]        RasNextType,
    output logic [PTR_W-1:0]  RasTop,
    output logic [PTR_W:0]    RasCnt
);

    localparam logic [PTR_W-1:0] TOP_INIT = PTR_W'(RAS_DEPTH - 1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(RAS_DEPTH);

    logic [PTR_W-1:0]  top_q, top_d, ras_top_q;
    logic [PTR_W:0]    cnt_q, cnt_d, ras_cnt_q;
    logic              able_q, able_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [2:0]        type_q, type_d;

    logic              wr_en_d, wr_en;
    logic [PTR_W-1:0]  wr_idx;
    logic [ADDR_W-1:0] wr_addr, rd_addr, ret_addr;

    assign ret_addr = InstCallPc + ADDR_W'(4);
    assign wr_en    = wr_en_d & (Rest != EnableValue);

`ifdef RAS_RECURSION_CNT_EN
    logic [3:0] wr_ctr, rd_ctr;
`endif

    ras_stack_mem #(.RAS_DEPTH(RAS_DEPTH), .PTR_W(PTR_W), .ADDR_W(ADDR_W)) u_mem (
        .clk     (Clk),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_addr (wr_addr),
`ifdef RAS_RECURSION_CNT_EN
        .wr_ctr  (wr_ctr),
        .rd_ctr  (rd_ctr),
`endif
        .rd_idx  (top_q),
        .rd_addr (rd_addr)
    );

    always_comb begin
        top_d   = top_q;
        cnt_d   = cnt_q;
        able_d  = 1'b0;
        pc_d    = ADDR_W'(ZeorDate);
        type_d  = 3'd0;
        wr_en_d = 1'b0;
        wr_idx  = top_q + PTR_W'(1);
        wr_addr = ret_addr;
`ifdef RAS_RECURSION_CNT_EN
        wr_ctr  = 4'd0;
`endif
        if (RecoverAble == AbleValue) begin
            top_d = RecoverTop;
            cnt_d = (RecoverCnt > CNT_FULL) ? CNT_FULL : RecoverCnt;
        end else if (InstNextAble == AbleValue) begin
            able_d = 1'b1;
            pc_d   = InstNextPc;
            type_d = InstNextType;
            case (InstNextType)
                TypeCALL: begin
                    wr_en_d = 1'b1;
`ifdef RAS_RECURSION_CNT_EN
                    // Recursive call to the same site: bump the counter in place.
                    if (cnt_q != '0 && rd_addr == ret_addr && rd_ctr != CtrMax) begin
                        wr_idx = top_q;
                        wr_ctr = rd_ctr + 4'd1;
                    end else begin
                        top_d = top_q + PTR_W'(1);
                        cnt_d = (cnt_q == CNT_FULL) ? CNT_FULL : cnt_q + 1'b1;
                    end
`else
                    top_d = top_q + PTR_W'(1);
                    cnt_d = (cnt_q == CNT_FULL) ? CNT_FULL : cnt_q + 1'b1;
`endif
                end
                TypeRET: begin
`ifdef RAS_RECURSION_CNT_EN
                    if (cnt_q != '0 && rd_ctr != 4'd0) begin
                        pc_d    = rd_addr;
                        wr_en_d = 1'b1;
                        wr_idx  = top_q;
                        wr_addr = rd_addr;
                        wr_ctr  = rd_ctr - 4'd1;
                    end else
`endif
                    if (cnt_q != '0) begin
                        pc_d  = rd_addr;
                        top_d = top_q - PTR_W'(1);
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rest == EnableValue) begin
            top_q     <= TOP_INIT;
            cnt_q     <= '0;
            able_q    <= 1'b0;
            pc_q      <= '0;
            type_q    <= 3'd0;
            ras_top_q <= TOP_INIT;
            ras_cnt_q <= '0;
        end else begin
            top_q     <= top_d;
            cnt_q     <= cnt_d;
            able_q    <= able_d;
            pc_q      <= pc_d;
            type_q    <= type_d;
            ras_top_q <= top_q;
            ras_cnt_q <= cnt_q;
        end
    end

    assign RasNextAble = able_q;
    assign RasNextPc   = pc_q;
    assign RasNextType = type_q;
    assign RasTop      = ras_top_q;
    assign RasCnt      = ras_cnt_q;

endmodule
